// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM arbiter between the fetch path (I) and the
// execute/data path (D). At most one grant per cycle; read data (or a store
// acknowledge) comes back exactly one cycle after the grant. A taken branch
// (i_flush_i) blocks a fetch grant and kills a fetch response in the same cycle.
//
// Ports:
//   m_clock, p_reset              clock, asynchronous active-high reset
//   i_valid_i/i_ready_o/i_addr_i  fetch request handshake and byte address
//   i_flush_i                     branch taken
//   i_rvalid_o/i_rdata_o          fetch response
//   d_valid_i/d_ready_o/d_addr_i  data request handshake and byte address
//   d_write_i/d_width_i/d_wdata_i store flag, access width, store data
//   d_rvalid_o/d_rdata_o          load data / store ack (rdata 0 on ack)
//   mem_*                         RAM port; mem_rdata_i valid the cycle after mem_en_o
//
// Build option: MEM_ARB_FAIR_EN enables the data-streak counter and the
// fairness override that grants a waiting fetch after MAX_DSTREAK data grants.
// Without it, data has strict priority and fetch can starve.

module mem_arbiter #(
  parameter int MAX_DSTREAK = 4
) (
  input  logic        m_clock,
  input  logic        p_reset,
  input  logic        i_valid_i,
  output logic        i_ready_o,
  input  logic [31:0] i_addr_i,
  input  logic        i_flush_i,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  input  logic        d_valid_i,
  output logic        d_ready_o,
  input  logic [31:0] d_addr_i,
  input  logic        d_write_i,
  input  logic [1:0]  d_width_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_width_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } own_t;

  own_t own_r;
  logic wr_r;
  logic grant_i_s;
  logic grant_d_s;
  logic fair_s;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);
  logic [3:0] dstreak_r;
`endif

  // Grant decision; grants are suppressed while reset is held so the RAM
  // sees no access during reset.
  always_comb begin
`ifdef MEM_ARB_FAIR_EN
    fair_s = (dstreak_r == MAX_S) && i_valid_i && !i_flush_i;
`else
    fair_s = 1'b0;
`endif
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (p_reset) begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end else if (d_valid_i && !fair_s) begin
      grant_d_s = 1'b1;
    end else if (i_valid_i && !i_flush_i) begin
      grant_i_s = 1'b1;
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  assign i_ready_o = grant_i_s;
  assign d_ready_o = grant_d_s;

  // RAM port mux: follows the granted requester, all zero when idle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'h0000_0000;
    mem_width_o = 2'b00;
    mem_wdata_o = 32'h0000_0000;
    if (grant_d_s) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_write_i;
      mem_addr_o  = d_addr_i;
      mem_width_o = d_width_i;
      mem_wdata_o = d_wdata_i;
    end else if (grant_i_s) begin
      mem_en_o    = 1'b1;
      mem_we_o    = 1'b0;
      mem_addr_o  = i_addr_i;
      mem_width_o = 2'b10;
      mem_wdata_o = 32'h0000_0000;
    end else begin
      mem_en_o    = 1'b0;
    end
  end

  // Response owner pipeline (1 deep) plus the data-streak counter.
  always_ff @(posedge m_clock or posedge p_reset) begin
    if (p_reset) begin
      own_r     <= NONE;
      wr_r      <= 1'b0;
`ifdef MEM_ARB_FAIR_EN
      dstreak_r <= 4'd0;
`endif
    end else begin
      if (grant_d_s) begin
        own_r <= OWN_D;
        wr_r  <= d_write_i;
      end else if (grant_i_s) begin
        own_r <= OWN_I;
        wr_r  <= 1'b0;
      end else begin
        own_r <= NONE;
        wr_r  <= 1'b0;
      end
`ifdef MEM_ARB_FAIR_EN
      // Counts data grants that overtook a waiting fetch; saturates at the cap.
      if (grant_i_s || !i_valid_i) begin
        dstreak_r <= 4'd0;
      end else if (grant_d_s && (dstreak_r != MAX_S)) begin
        dstreak_r <= dstreak_r + 4'd1;
      end else begin
        dstreak_r <= dstreak_r;
      end
`endif
    end
  end

  // Response steering; a flush in the response cycle drops a fetch response.
  always_comb begin
    i_rvalid_o = 1'b0;
    i_rdata_o  = 32'h0000_0000;
    d_rvalid_o = 1'b0;
    d_rdata_o  = 32'h0000_0000;
    case (own_r)
      OWN_I: begin
        i_rvalid_o = !i_flush_i;
        i_rdata_o  = mem_rdata_i;
      end
      OWN_D: begin
        d_rvalid_o = 1'b1;
        d_rdata_o  = wr_r ? 32'h0000_0000 : mem_rdata_i;
      end
      default: begin
        i_rvalid_o = 1'b0;
        d_rvalid_o = 1'b0;
      end
    endcase
  end

endmodule
